snn_sched: RTL and testbench
============================

SNN_SCHED -- requirements
Module: snn_sched

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 98, meaning image bytes per inference (8 pixels per byte, 784 pixels).
REQ-002 SHALL have parameter ASCII_BASE, default 8'h30, meaning the offset added to the digit for the UART result byte.
REQ-003 SHALL have ports: clk  in  1  system clock, the only clock.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: rx_rdy  in  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have ports: rx_data  in  8  received image byte.
REQ-007 SHALL have ports: core_addr  in  10  pixel address from the inference core.
REQ-008 SHALL have ports: core_q  out  1  pixel value for core_addr.
REQ-009 SHALL have ports: core_start  out  1  one-cycle inference start pulse.
REQ-010 SHALL have ports: core_done  in  1  one-cycle inference-complete strobe.
REQ-011 SHALL have ports: core_digit  in  4  classified digit, valid with core_done.
REQ-012 SHALL have ports: tx_start  out  1  one-cycle UART transmit request.
REQ-013 SHALL have ports: tx_data  out  8  byte to transmit, valid with tx_start.
REQ-014 SHALL have ports: tx_busy  in  1  transmitter busy, tx_start not allowed.
REQ-015 SHALL have ports: busy  out  1  high in START, RUN and REPORT.
REQ-016 SHALL have ports: result  out  4  last classified digit, held until the next core_done.
REQ-017 SHALL have ports: overrun  out  1  sticky flag, a byte was dropped.

Function
REQ-018 SHALL hold a 784x1 pixel memory; byte k bit j (LSB first) SHALL be written to address 8k+j.
REQ-019 SHALL register core_q = mem[core_addr] with exactly one cycle of read latency, which matches the weight ROMs.
REQ-020 SHALL implement states LOAD, START, RUN, REPORT.
REQ-021 LOAD: each rx_rdy SHALL store one byte and increment byte_cnt; an rx_rdy with byte_cnt==NUM_BYTES-1 SHALL store the byte, clear byte_cnt and go to START.
REQ-022 START: core_start SHALL be high for exactly this one cycle, then the state SHALL go to RUN.
REQ-023 RUN: on core_done the block SHALL latch core_digit into result and go to REPORT; otherwise it SHALL stay in RUN.
REQ-024 REPORT: while tx_busy is high it SHALL wait; with tx_busy low it SHALL pulse tx_start for one cycle and return to LOAD.
REQ-025 tx_data SHALL be ASCII_BASE+result for result<=9, and 8'h3F ('?') for result>9 (8-bit add, no carry out).
REQ-026 rx_rdy outside LOAD SHALL be dropped: memory and byte_cnt unchanged, overrun set.
REQ-027 overrun SHALL clear when the first byte (byte_cnt==0) of the next image is accepted; a simultaneous drop is not possible, because accepting only happens in LOAD.
REQ-028 core_done outside RUN SHALL be ignored.
REQ-029 Pixel memory SHALL NOT be written outside LOAD, so the image stays stable for the whole inference.

Reset
REQ-030 rst high SHALL force, at any time including mid-inference: state=LOAD, byte_cnt=0, core_start=0, tx_start=0, tx_data=0, busy=0, result=0, overrun=0, core_q=0.
REQ-031 Pixel memory contents SHALL NOT be reset; they are undefined until loaded.
REQ-032 After rst deasserts, the first rx_rdy SHALL be treated as byte 0.

Configuration
REQ-033 Macro SNN_SCHED_WDOG_EN defined: a 16-bit cycle counter SHALL run in RUN.
REQ-034 With SNN_SCHED_WDOG_EN defined, if the counter reaches 16'hFFFF without core_done, the block SHALL go to REPORT with result=4'hF, which transmits '?'.
REQ-035 With SNN_SCHED_WDOG_EN defined, the counter SHALL clear on entry to RUN.
REQ-036 Macro SNN_SCHED_WDOG_EN undefined: there SHALL be no counter, and RUN SHALL wait indefinitely.

Verification
REQ-037 Test 1: 98 bytes of 8'hA5, then core_addr sweeps 0..783 -> core_q one cycle later = 1,0,1,0,0,1,0,1 repeating; one core_start pulse 1 cycle after byte 98.
REQ-038 Test 2: core_done with core_digit=7, tx_busy=0 -> result=7; tx_start pulse with tx_data=8'h37 one cycle after REPORT entry; busy drops.
REQ-039 Test 3: tx_busy held high 20 cycles in REPORT -> tx_start stays 0; it pulses once on the first cycle tx_busy is low.
REQ-040 Test 4: rx_rdy during RUN -> overrun=1 and pixel memory unchanged; the next image's byte 0 clears overrun.
REQ-041 Test 5: rst asserted after 50 bytes -> all outputs 0; then 98 fresh bytes -> core_start after byte 98, not after 48.
REQ-042 Test 6 (SNN_SCHED_WDOG_EN): no core_done for 65535 cycles -> tx_data=8'h3F and result=4'hF.

Source files
------------

// File: rtl/snn_sched.sv
// snn_sched: image loader and inference scheduler for the SNN digit classifier.
// Collects NUM_BYTES UART bytes into a 1-bit pixel memory, kicks the inference
// core, waits for its verdict and sends the digit back as an ASCII byte.
// Optional build macro: SNN_SCHED_WDOG_EN adds a 16-bit watchdog in RUN that
// reports '?' (result 4'hF) when the core never answers.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LOAD   | accept image bytes from the UART into pixel memory
//   START  | one-cycle core_start pulse towards the inference core
//   RUN    | inference in progress, waiting for core_done
//   REPORT | waiting for a free transmitter, then send the ASCII result
module snn_sched #(
    parameter int          NUM_BYTES  = 98,
    parameter logic [7:0]  ASCII_BASE = 8'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    input  logic [9:0]  core_addr,
    output logic        core_q,
    output logic        core_start,
    input  logic        core_done,
    input  logic [3:0]  core_digit,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        busy,
    output logic [3:0]  result,
    output logic        overrun
);

    localparam int            CW        = $clog2(NUM_BYTES);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);
    localparam logic [9:0]    NUM_PIX   = 10'(NUM_BYTES * 8);

    typedef enum logic [1:0] {LOAD, START, RUN, REPORT} state_t;

    state_t        state;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    mem [0:NUM_BYTES-1];
    logic          load_wr;

`ifdef SNN_SCHED_WDOG_EN
    logic [15:0]   wdog_cnt;
`endif

    // Bytes are stored whole; pixel 8k+j is bit j of byte k, so no bit scatter is needed.
    assign load_wr = (state == LOAD) && rx_rdy;

    // Pixel memory write port: only in LOAD, so the image is frozen during inference.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[byte_cnt] <= rx_data;
        end
    end

    // Registered pixel read, one cycle latency to line up with the weight ROMs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_q <= 1'b0;
        end else if (core_addr < NUM_PIX) begin
            core_q <= mem[core_addr[9:3]][core_addr[2:0]];
        end else begin
            core_q <= 1'b0;
        end
    end

    // Sequencer with registered strobes, status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            byte_cnt   <= '0;
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            result     <= 4'h0;
            overrun    <= 1'b0;
`ifdef SNN_SCHED_WDOG_EN
            wdog_cnt   <= 16'h0000;
`endif
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            if (rx_rdy && (state != LOAD)) begin
                overrun <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (rx_rdy) begin
                        if (byte_cnt == '0) begin
                            overrun <= 1'b0;
                        end
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt   <= '0;
                            state      <= START;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    state <= RUN;
`ifdef SNN_SCHED_WDOG_EN
                    wdog_cnt <= 16'h0000;
`endif
                end
                RUN: begin
                    if (core_done) begin
                        result <= core_digit;
                        state  <= REPORT;
                    end
`ifdef SNN_SCHED_WDOG_EN
                    else if (wdog_cnt == 16'hFFFF) begin
                        result <= 4'hF;
                        state  <= REPORT;
                    end else begin
                        wdog_cnt <= wdog_cnt + 16'd1;
                    end
`endif
                end
                REPORT: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= (result <= 4'd9) ? (ASCII_BASE + {4'h0, result}) : 8'h3F;
                        busy     <= 1'b0;
                        state    <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_sched.sv
// Directed bench for snn_sched: pixel and transmit scoreboards fed from the stimulus.
module tb_snn_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [9:0] core_addr;
    logic       core_q;
    logic       core_start;
    logic       core_done;
    logic [3:0] core_digit;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       busy;
    logic [3:0] result;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] img [0:97];
    logic       exp_pix_q [$];
    logic [7:0] exp_tx_q  [$];

    snn_sched dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .core_addr  (core_addr),
        .core_q     (core_q),
        .core_start (core_start),
        .core_done  (core_done),
        .core_digit (core_digit),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .result     (result),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_tx_start"},   tx_start,   0);
        chk({tag, "_tx_data"},    tx_data,    0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_result"},     result,     0);
        chk({tag, "_overrun"},    overrun,    0);
        chk({tag, "_core_q"},     core_q,     0);
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic load_image(input int kind);
        logic [7:0] b;
        for (int i = 0; i < 98; i++) begin
            case (kind)
                0:       b = 8'hA5;
                1:       b = 8'($urandom_range(0, 255));
                default: b = 8'((i * 37 + 11) & 255);
            endcase
            img[i] = b;
            send_byte(b);
            chk("core_start_after_byte", core_start, (i == 97) ? 1 : 0);
        end
        chk("busy_in_start", busy, 1);
        @(negedge clk);
        chk("core_start_single", core_start, 0);
        chk("busy_in_run", busy, 1);
    endtask

    task automatic sweep();
        logic [7:0] b;
        for (int a = 0; a < 784; a++) begin
            core_addr = 10'(a);
            b = img[a / 8];
            exp_pix_q.push_back(b[a % 8]);
            @(negedge clk);
            chk("core_q", core_q, exp_pix_q.pop_front());
        end
    endtask

    task automatic tx_expect(input string tag, input logic [3:0] exp_res);
        chk({tag, "_tx_start"}, tx_start, 1);
        chk({tag, "_tx_data"},  tx_data,  exp_tx_q.pop_front());
        chk({tag, "_result"},   result,   exp_res);
        chk({tag, "_busy"},     busy,     0);
        @(negedge clk);
        chk({tag, "_tx_single"}, tx_start, 0);
    endtask

    initial begin
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; core_addr = 10'd0;
        core_done = 1'b0; core_digit = 4'h0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Test 1: A5 image, sweep all pixels, single start pulse after byte 98.
        load_image(0);
        sweep();

        // Test 2: digit 7 with an idle transmitter.
        core_digit = 4'd7; core_done = 1'b1;
        exp_tx_q.push_back(8'h37);
        @(negedge clk);
        core_done = 1'b0;
        chk("t2_result", result, 7);
        chk("t2_tx_early", tx_start, 0);
        chk("t2_busy_report", busy, 1);
        @(negedge clk);
        tx_expect("t2", 4'd7);

        // core_done outside RUN is ignored.
        core_digit = 4'd3; core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        chk("done_in_load_ignored", result, 7);
        chk("done_in_load_busy", busy, 0);

        // Test 4: rx_rdy during RUN is dropped and flagged.
        load_image(1);
        send_byte(~img[0]);
        chk("t4_overrun", overrun, 1);
        chk("t4_busy", busy, 1);
        sweep();

        // Test 3: transmitter busy for 20 cycles in REPORT; digit 10 reports '?'.
        tx_busy = 1'b1;
        core_digit = 4'd10; core_done = 1'b1;
        exp_tx_q.push_back(8'h3F);
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_tx_held", tx_start, 0);
        end
        chk("t3_busy_waiting", busy, 1);
        tx_busy = 1'b0;
        @(negedge clk);
        tx_expect("t3", 4'd10);
        chk("t4_overrun_sticky", overrun, 1);

        // Test 5: 50 bytes of a new image, first one clears overrun, then async reset.
        for (int i = 0; i < 50; i++) begin
            img[i] = 8'hFF;
            send_byte(8'hFF);
            if (i == 0) chk("t4_overrun_cleared", overrun, 0);
        end
        core_addr = 10'd0;
        @(negedge clk);
        chk("t5_core_q_pre", core_q, 1);
        #2 rst = 1'b1;
        #1 outputs_zero("t5_async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_image(2);
        sweep();
        core_digit = 4'd9; core_done = 1'b1;
        exp_tx_q.push_back(8'h39);
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        tx_expect("t5", 4'd9);

`ifdef SNN_SCHED_WDOG_EN
        // Test 6: no answer from the core, the watchdog reports '?'.
        begin
            int n;
            load_image(1);
            exp_tx_q.push_back(8'h3F);
            n = 0;
            while (tx_start !== 1'b1 && n < 70000) begin
                @(negedge clk);
                n++;
            end
            chk("t6_not_early", (n > 65000) ? 1 : 0, 1);
            tx_expect("t6", 4'hF);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
